// File: rtl/tx_fifo_rd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_fifo_rd_sched_pkg
// Brief   : Shared LMAC TX types: scheduler states, rate pacing, header layout.
// Rev     : 1.0
// ============================================================================
package tx_fifo_rd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_WAIT_FILL = 3'd2,
    ST_XFER      = 3'd3,
    ST_DROP      = 3'd4,
    ST_IPG       = 3'd5
  } sched_state_e;

  typedef enum logic [2:0] {
    RATE_NONE = 3'd0,
    RATE_10G  = 3'd1,
    RATE_5G   = 3'd2,
    RATE_2P5G = 3'd3,
    RATE_1G   = 3'd4
  } rate_e;

  localparam logic [3:0] c_pace_div_10g  = 4'd1;
  localparam logic [3:0] c_pace_div_5g   = 4'd2;
  localparam logic [3:0] c_pace_div_2p5g = 4'd4;
  localparam logic [3:0] c_pace_div_1g   = 4'd10;

  localparam int unsigned c_hdr_len_lsb = 0;
  localparam int unsigned c_hdr_len_w   = 14;
  localparam int unsigned c_word_cnt_w  = 11;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  bytes;
  } skid_word_t;

  function automatic rate_e rate_select(input logic m10, input logic m5,
                                        input logic m2p5, input logic m1);
    if (m10)       return RATE_10G;
    else if (m5)   return RATE_5G;
    else if (m2p5) return RATE_2P5G;
    else if (m1)   return RATE_1G;
    else           return RATE_NONE;
  endfunction

  function automatic logic [3:0] pace_div(input rate_e rate);
    case (rate)
      RATE_10G:  return c_pace_div_10g;
      RATE_5G:   return c_pace_div_5g;
      RATE_2P5G: return c_pace_div_2p5g;
      RATE_1G:   return c_pace_div_1g;
      default:   return c_pace_div_10g;
    endcase
  endfunction

  function automatic logic [c_word_cnt_w-1:0] len_to_words(input logic [c_hdr_len_w-1:0] len);
    return c_word_cnt_w'(({1'b0, len} + 15'd7) >> 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_sched_skid.sv
`default_nettype none
// ============================================================================
// Module  : tx_sched_skid
// Brief   : Two-entry output skid buffer; head entry drives the MAC TX port.
// Rev     : 1.0
// ============================================================================
module tx_sched_skid
  import tx_fifo_rd_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  skid_word_t  push_word,
  input  logic        pop,
  output logic [1:0]  count,
  output logic        out_valid,
  output skid_word_t  out_word
);

  skid_word_t r_ent0;
  skid_word_t r_ent1;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  // Entry 0 is always the head, so the presented word only moves on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= push_word;
          else                 r_ent1 <= push_word;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_ent0 <= push_word;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = r_count;
  assign out_valid = (r_count != 2'd0);
  assign out_word  = r_ent0;

endmodule
`default_nettype wire

// File: rtl/tx_fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tx_fifo_rd_sched
// Brief   : Paced TX FIFO read scheduler with cut-through start and length drop.
// Rev     : 1.0
// ============================================================================
module tx_fifo_rd_sched
  import tx_fifo_rd_sched_pkg::*;
#(
  parameter int unsigned CT_THRESH  = 16,
  parameter int unsigned IPG_CYCLES = 2,
  parameter int unsigned MIN_LEN    = 64,
  parameter int unsigned MAX_LEN    = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_10g,
  input  logic        mode_5g,
  input  logic        mode_2p5g,
  input  logic        mode_1g,
  input  logic [63:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic [12:0] fifo_usedw,
  output logic        fifo_rd_en,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] tx_data,
  output logic        tx_last,
  output logic [2:0]  tx_bytes,
  output logic        pkt_err,
  output logic        busy
);

  localparam int unsigned c_ipg_w = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [c_ipg_w-1:0] c_ipg_last  = c_ipg_w'(IPG_CYCLES - 1);
  localparam logic [12:0]        c_ct_thresh = 13'(CT_THRESH);

  sched_state_e r_state;
  sched_state_e w_state_nxt;

  rate_e      w_rate;
  rate_e      r_rate;
  logic [3:0] r_pace_cnt;
  logic [3:0] w_pace_div;
  logic       w_rate_chg;
  logic       w_pace_tick;

  logic                    r_armed;
  logic [c_word_cnt_w-1:0] r_words;
  logic [c_word_cnt_w-1:0] r_wcnt;
  logic [2:0]              r_bytes;
  logic [c_ipg_w-1:0]      r_ipg_cnt;
  logic                    r_rd_payload;
  logic                    r_rd_last;

  logic [c_hdr_len_w-1:0]  w_hdr_len;
  logic [c_word_cnt_w-1:0] w_hdr_words;
  logic                    w_hdr_bad;
  logic [12:0]             w_fill_tgt;

  logic [1:0]  w_skid_cnt;
  logic [2:0]  w_occ;
  logic        w_credit;
  logic        w_deq;
  logic        w_rd_en;
  logic        w_err;
  skid_word_t  w_push_word;
  skid_word_t  w_out_word;

  // Rate pacing: counter restarts whenever the priority-resolved rate changes
  always_comb begin
    w_rate      = rate_select(mode_10g, mode_5g, mode_2p5g, mode_1g);
    w_rate_chg  = (w_rate != r_rate);
    w_pace_div  = pace_div(r_rate);
    w_pace_tick = (r_rate != RATE_NONE) && !w_rate_chg &&
                  (r_pace_cnt == (w_pace_div - 4'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate     <= RATE_NONE;
      r_pace_cnt <= 4'd0;
    end else begin
      r_rate <= w_rate;
      if (w_rate_chg || w_pace_tick || (r_rate == RATE_NONE)) r_pace_cnt <= 4'd0;
      else                                                     r_pace_cnt <= r_pace_cnt + 4'd1;
    end
  end

  always_comb begin
    w_hdr_len   = fifo_dout[c_hdr_len_lsb +: c_hdr_len_w];
    w_hdr_words = len_to_words(w_hdr_len);
    w_hdr_bad   = ({18'd0, w_hdr_len} < MIN_LEN) || ({18'd0, w_hdr_len} > MAX_LEN);
    w_fill_tgt  = ({2'b00, r_words} < c_ct_thresh) ? {2'b00, r_words} : c_ct_thresh;
  end

  // Credit counts skid occupancy net of this cycle's handshake, so a word
  // leaving now frees room for a pop now and 10G can stream at full rate.
  assign w_deq    = tx_valid && tx_ready;
  assign w_occ    = {1'b0, w_skid_cnt} + {2'b00, r_rd_payload} - {2'b00, w_deq};
  assign w_credit = (w_occ < 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !fifo_empty) begin
          w_rd_en     = 1'b1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_hdr_bad) begin
          w_err       = 1'b1;
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt = ST_WAIT_FILL;
        end
      end
      ST_WAIT_FILL: begin
        if (fifo_usedw >= w_fill_tgt) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        w_rd_en = w_pace_tick && !fifo_empty && w_credit && (r_wcnt != r_words);
        if (w_deq && tx_last) w_state_nxt = (IPG_CYCLES == 0) ? ST_IDLE : ST_IPG;
      end
      ST_DROP: begin
        if (r_wcnt == r_words) w_state_nxt = ST_IDLE;
        else                   w_rd_en     = !fifo_empty;
      end
      ST_IPG: begin
        if (r_ipg_cnt == c_ipg_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_words      <= '0;
      r_wcnt       <= '0;
      r_bytes      <= 3'd0;
      r_ipg_cnt    <= '0;
      r_rd_payload <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_armed      <= 1'b1;
      r_rd_payload <= w_rd_en && (r_state == ST_XFER);
      r_rd_last    <= w_rd_en && (r_state == ST_XFER) &&
                      ((r_wcnt + c_word_cnt_w'(1)) == r_words);
      if (r_state == ST_HDR) begin
        r_words <= w_hdr_words;
        r_bytes <= w_hdr_len[2:0];
        r_wcnt  <= '0;
      end else if (w_rd_en && ((r_state == ST_XFER) || (r_state == ST_DROP))) begin
        r_wcnt <= r_wcnt + c_word_cnt_w'(1);
      end
      if (r_state == ST_IPG) r_ipg_cnt <= r_ipg_cnt + c_ipg_w'(1);
      else                   r_ipg_cnt <= '0;
    end
  end

  assign w_push_word.data  = fifo_dout;
  assign w_push_word.last  = r_rd_last;
  assign w_push_word.bytes = r_rd_last ? r_bytes : 3'd0;

  tx_sched_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (r_rd_payload),
    .push_word (w_push_word),
    .pop       (tx_ready),
    .count     (w_skid_cnt),
    .out_valid (tx_valid),
    .out_word  (w_out_word)
  );

  assign tx_data    = w_out_word.data;
  assign tx_last    = w_out_word.last;
  assign tx_bytes   = w_out_word.bytes;
  assign fifo_rd_en = w_rd_en && !rst;
  assign pkt_err    = w_err && !rst;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_fifo_rd_sched
// Brief   : Directed self-checking bench for tx_fifo_rd_sched with a FIFO model.
// Rev     : 1.0
// ============================================================================
module tb_tx_fifo_rd_sched;

  localparam int unsigned CT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_10g = 1'b1, mode_5g = 1'b0, mode_2p5g = 1'b0, mode_1g = 1'b0;
  logic [63:0] fifo_dout = '0;
  logic        fifo_empty;
  logic [12:0] fifo_usedw;
  logic        fifo_rd_en;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [63:0] tx_data;
  logic        tx_last;
  logic [2:0]  tx_bytes;
  logic        pkt_err;
  logic        busy;

  tx_fifo_rd_sched #(
    .CT_THRESH(CT), .IPG_CYCLES(2), .MIN_LEN(64), .MAX_LEN(9600)
  ) u_dut (
    .clk(clk), .rst(rst),
    .mode_10g(mode_10g), .mode_5g(mode_5g), .mode_2p5g(mode_2p5g), .mode_1g(mode_1g),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
    .fifo_rd_en(fifo_rd_en),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_bytes(tx_bytes),
    .pkt_err(pkt_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // FIFO model: show-ahead-free, read data one cycle after the pop
  logic [63:0] mem [0:1023];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        flush = 1'b0;
  int          underflow = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_usedw = 13'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      if (fifo_empty) underflow <= underflow + 1;
      else begin
        fifo_dout <= mem[rd_ptr % 1024];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  logic ready_tgl = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = ready_tgl ? ~tx_ready : 1'b1;
  end

  // Monitor samples on the falling edge; inputs change just after the rising edge
  logic [63:0] rx_data[$];
  logic        rx_last[$];
  logic [2:0]  rx_bytes[$];
  int          rd_cyc[$];
  int          valid_cyc[$];
  int          err_pulses = 0;
  int          stall_viol = 0;
  logic        mon_clr = 1'b0;
  logic        prev_stall = 1'b0;
  logic [67:0] prev_word = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      rx_data.delete(); rx_last.delete(); rx_bytes.delete();
      rd_cyc.delete(); valid_cyc.delete();
      err_pulses = 0;
    end else if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || ({tx_data, tx_last, tx_bytes} != prev_word))) stall_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_data, tx_last, tx_bytes};
      if (tx_valid && tx_ready) begin
        rx_data.push_back(tx_data);
        rx_last.push_back(tx_last);
        rx_bytes.push_back(tx_bytes);
      end
      if (tx_valid)   valid_cyc.push_back(cyc);
      if (fifo_rd_en) rd_cyc.push_back(cyc);
      if (pkt_err)    err_pulses++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pay(input int p, input int i);
    return {16'hD000 | 16'(p), 16'h5A5A, 32'(i)};
  endfunction

  task automatic push_word(input logic [63:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_hdr(input int len);
    push_word({16'hBEEF, 34'd0, 14'(len)});
  endtask

  task automatic push_pay(input int p, input int first, input int n);
    for (int i = first; i < first + n; i++) push_word(pay(p, i));
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    step(1);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (rx_data.size() < n) check({tag, "_timeout"}, 64'(rx_data.size()), 64'(n));
  endtask

  task automatic check_pkt(input string tag, input int p, input int n, input logic [2:0] bytes);
    int bad = 0;
    check({tag, "_count"}, 64'(rx_data.size()), 64'(n));
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== pay(p, i)) bad++;
      if (rx_last[i] !== (i == n - 1)) bad++;
    end
    check({tag, "_data"}, 64'(bad), 64'd0);
    check({tag, "_bytes"}, (rx_bytes.size() != 0) ? 64'(rx_bytes[$]) : 64'hFF, 64'(bytes));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;

    // Reset state, with the first packet already waiting in the FIFO
    step(3);
    check("rst_ctl", {58'd0, fifo_rd_en, tx_valid, tx_last, tx_bytes, pkt_err, busy}, 64'd0);
    check("rst_data", tx_data, 64'd0);
    push_hdr(64);
    push_pay(1, 0, 8);
    rst = 1'b0;
    @(negedge clk);
    check("t1_no_early_pop", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk);
    check("t1_hdr_pop", {63'd0, fifo_rd_en}, 64'd1);

    // 10G, 64-byte packet, ready held high
    wait_rx(8, 200, "t1");
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      k++;
    end
    check("t1_ipg", 64'(k), 64'd2);
    check_pkt("t1", 1, 8, 3'd0);
    check("t1_valid_cycles", 64'(valid_cyc.size()), 64'd8);
    check("t1_b2b_span", 64'(valid_cyc[$] - valid_cyc[0]), 64'd7);
    check("t1_pops", 64'(rd_cyc.size()), 64'd9);

    // 1G, 100-byte packet: payload pops every 10 cycles
    step(2);
    clear_mon();
    mode_10g = 1'b0;
    mode_1g  = 1'b1;
    push_hdr(100);
    push_pay(2, 0, 13);
    wait_rx(13, 400, "t2");
    check_pkt("t2", 2, 13, 3'd4);
    check("t2_pops", 64'(rd_cyc.size()), 64'd14);
    bad = 0;
    for (int i = 2; i < rd_cyc.size(); i++) if (rd_cyc[i] - rd_cyc[i-1] != 10) bad++;
    check("t2_pop_spacing", 64'(bad), 64'd0);

    // Illegal length 20 then a good packet
    step(5);
    mode_1g  = 1'b0;
    mode_10g = 1'b1;
    clear_mon();
    push_hdr(20);
    push_pay(3, 0, 3);
    push_hdr(64);
    push_pay(4, 0, 8);
    wait_rx(8, 300, "t3");
    check_pkt("t3", 4, 8, 3'd0);
    check("t3_err_pulses", 64'(err_pulses), 64'd1);
    check("t3_pops", 64'(rd_cyc.size()), 64'd13);
    check("t3_valid_cycles", 64'(valid_cyc.size()), 64'd8);

    // 1500 bytes with ready toggling every cycle
    step(5);
    clear_mon();
    ready_tgl = 1'b1;
    push_hdr(1500);
    push_pay(5, 0, 188);
    wait_rx(188, 2000, "t4");
    ready_tgl = 1'b0;
    check_pkt("t4", 5, 188, 3'd4);
    check("t4_stall_stable", 64'(stall_viol), 64'd0);

    // Underrun after word 5 of 16, FIFO empty for 7 cycles
    step(6);
    clear_mon();
    push_hdr(128);
    push_pay(6, 0, 5);
    k = 0;
    while (rd_ptr != wr_ptr && k < 200) begin
      step(1);
      k++;
    end
    if (rd_ptr != wr_ptr) check("t5_drain_timeout", 64'(rd_ptr), 64'(wr_ptr));
    step(5);
    check("t5_gap_valid", {63'd0, tx_valid}, 64'd0);
    check("t5_gap_busy", {63'd0, busy}, 64'd1);
    check("t5_gap_rx", 64'(rx_data.size()), 64'd5);
    step(2);
    push_pay(6, 5, 11);
    wait_rx(16, 300, "t5");
    check_pkt("t5", 6, 16, 3'd0);

    // Reset pulsed mid-transfer, then a fresh packet
    step(5);
    clear_mon();
    push_hdr(64);
    push_pay(7, 0, 8);
    wait_rx(3, 100, "t6_pre");
    rst   = 1'b1;
    flush = 1'b1;
    step(1);
    rst   = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("t6_rst_ctl", {58'd0, fifo_rd_en, tx_valid, tx_last, tx_bytes, pkt_err, busy}, 64'd0);
    check("t6_rst_data", tx_data, 64'd0);
    step(1);
    clear_mon();
    push_hdr(64);
    push_pay(8, 0, 8);
    wait_rx(8, 200, "t6");
    check_pkt("t6", 8, 8, 3'd0);

    step(5);
    check("fifo_underflow", 64'(underflow), 64'd0);
    check("stall_stable_all", 64'(stall_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
